// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply-divide unit with HI/LO result registers and MTHI/MTLO writes.
// Latency: DONE and the result appear WIDTH+1 edges after START is accepted. BUSY is high until the FIN->IDLE edge.
// Backpressure: none. The unit ignores START and HI/LO writes while BUSY, and control stalls on BUSY.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    input  logic             HI_WE,
    input  logic             LO_WE,
    input  logic [WIDTH-1:0] WD,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             steps_done;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             b_zero;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opd;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             div_zero_q;

    // Operand magnitudes and signs; the unsigned ops (OP[0]=1) treat bit W-1 as data
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        sign_a = ~OP[0] & SRC_A[WIDTH-1];
        sign_b = ~OP[0] & SRC_B[WIDTH-1];
        abs_a  = sign_a ? (~SRC_A + 1'b1) : SRC_A;
        abs_b  = sign_b ? (~SRC_B + 1'b1) : SRC_B;
    end

    // Multiply step: acc_hi:acc_lo shifts right, and the multiplier is consumed from acc_lo[0]
    logic [WIDTH:0] mul_sum;
    // Divide step: acc_hi holds the partial remainder, and acc_lo shifts the dividend out and the quotient in
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ok;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd};
        div_ok    = ~div_diff[WIDTH];
    end

    // Sign correction applied at the FIN load
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_lo ? (~prod + 1'b1) : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            res_hi = neg_hi ? (~acc_hi + 1'b1) : acc_hi;
            // A divisor of zero leaves the remainder equal to the dividend and forces the quotient to all ones
            if (b_zero) begin
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_lo = neg_lo ? (~acc_lo + 1'b1) : acc_lo;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            cnt        <= '0;
            steps_done <= 1'b0;
            is_div     <= 1'b0;
            neg_lo     <= 1'b0;
            neg_hi     <= 1'b0;
            b_zero     <= 1'b0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opd        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (HI_WE) hi_q <= WD;
                    if (LO_WE) lo_q <= WD;
                    if (START) begin
                        state      <= S_CALC;
                        cnt        <= '0;
                        steps_done <= 1'b0;
                        is_div     <= OP[1];
                        neg_lo     <= sign_a ^ sign_b;
                        neg_hi     <= sign_a;
                        b_zero     <= (SRC_B == '0);
                        acc_hi     <= '0;
                        if (OP[1]) begin
                            acc_lo <= abs_a;
                            opd    <= abs_b;
                        end else begin
                            acc_lo <= abs_b;
                            opd    <= abs_a;
                        end
                    end
                end
                S_CALC: begin
                    if (!steps_done) begin
                        if (is_div) begin
                            acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) steps_done <= 1'b1;
                    end else begin
                        state      <= S_FIN;
                        hi_q       <= res_hi;
                        lo_q       <= res_lo;
                        done_q     <= 1'b1;
                        div_zero_q <= is_div & b_zero;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY     = (state != S_IDLE);
    assign DONE     = done_q;
    assign DIV_ZERO = div_zero_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule
